ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 111 +++++++++++
 tb/tb_ram_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: wait-state, byte-addressed, big-endian RAM slave with an MFC handshake.
// Define RAM_ALIGN_CHECK_EN to flag misaligned accesses on MSET instead of forcing alignment.
module ram_responder #(
   parameter int WAIT_STATES = 2,
   parameter int DEPTH       = 512
) (
   input  logic        Clk,
   input  logic        RESET,
   input  logic        RAM_enable,
   input  logic [5:0]  RAM_OpCode,
   input  logic [8:0]  Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        MFC,
   output logic        MSET
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        armed_q;
   logic [3:0]  op_q;
   logic [8:0]  addr_q;
   logic [31:0] din_q;
   logic [31:0] dout_q;
   logic        mfc_q;
   logic        mset_q;
   logic [7:0]  mem_q [DEPTH];
   logic        half;
   logic        word;
   logic        bad;
   logic [8:0]  base;
   logic [8:0]  a1;
   logic [8:0]  a2;
   logic [8:0]  a3;
   logic [7:0]  b0;
   logic [31:0] rd_data;
   logic        unused;

   function automatic logic [8:0] wrap(input logic [8:0] a, input int k);
      return 9'((int'(a) + k) % DEPTH);
   endfunction

   assign unused = ^RAM_OpCode[5:4];
   assign half   = op_q[1:0] == 2'b01;
   assign word   = op_q[1];
`ifdef RAM_ALIGN_CHECK_EN
   assign bad    = (half & addr_q[0]) | (word & |addr_q[1:0]);
   assign base   = addr_q;
`else
   assign bad    = 1'b0;
   assign base   = {addr_q[8:2], word ? 2'b00 : {addr_q[1], addr_q[0] & ~half}};
`endif
   // successive bytes wrap modulo DEPTH so accesses near the top stay in range
   assign a1 = wrap(base, 1);
   assign a2 = wrap(base, 2);
   assign a3 = wrap(base, 3);
   assign b0 = mem_q[base];
   assign rd_data = word ? {b0, mem_q[a1], mem_q[a2], mem_q[a3]}
                  : half ? {{16{op_q[2] & b0[7]}}, b0, mem_q[a1]}
                  : {{24{op_q[2] & b0[7]}}, b0};

   always_ff @(posedge Clk) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b1;
         dout_q  <= '0;
         mfc_q   <= 1'b0;
         mset_q  <= 1'b0;
      end else begin
         mfc_q  <= 1'b0;
         mset_q <= 1'b0;
         if (!RAM_enable) armed_q <= 1'b1;
         case (state_q)
            IDLE: if (RAM_enable && armed_q) begin
               op_q    <= RAM_OpCode[3:0];
               addr_q  <= Address;
               din_q   <= DataIn;
               cnt_q   <= 4'(WAIT_STATES);
               armed_q <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: if (cnt_q == 4'd0) state_q <= DONE;
                  else cnt_q <= cnt_q - 4'd1;
            DONE: begin
               state_q <= IDLE;
               mfc_q   <= 1'b1;
               mset_q  <= bad;
               if (!bad && !op_q[3]) dout_q <= rd_data;
               if (!bad && op_q[3]) begin
                  if (word) begin
                     mem_q[base] <= din_q[31:24];
                     mem_q[a1]   <= din_q[23:16];
                     mem_q[a2]   <= din_q[15:8];
                     mem_q[a3]   <= din_q[7:0];
                  end else if (half) begin
                     mem_q[base] <= din_q[15:8];
                     mem_q[a1]   <= din_q[7:0];
                  end else
                     mem_q[base] <= din_q[7:0];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DataOut = dout_q;
   assign MFC     = mfc_q;
   assign MSET    = mset_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: random and directed transactions checked against a byte-array reference model.
module tb_ram_responder;
   localparam int WS = 2;
   localparam int DP = 512;
   logic        Clk = 1'b0;
   logic        RESET;
   logic        RAM_enable;
   logic [5:0]  RAM_OpCode;
   logic [8:0]  Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MFC;
   logic        MSET;
   logic [7:0]  m [DP];
   logic [31:0] dout_m;
   int          errors = 0;
   int          checks = 0;

   ram_responder #(.WAIT_STATES(WS), .DEPTH(DP)) dut (
      .Clk(Clk), .RESET(RESET), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
      .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MSET(MSET)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one transaction: applies it to the model, then checks latency, result and the single MFC pulse
   task automatic xact(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [8:0] a, input logic [31:0] d, input int hold);
      int n, lat, b;
      logic bad;
      logic [31:0] v;
      n = sz[1] ? 4 : (sz == 2'b01 ? 2 : 1);
`ifdef RAM_ALIGN_CHECK_EN
      bad = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
      b = int'(a);
`else
      bad = 1'b0;
      b = int'(a) - int'(a) % n;
`endif
      if (!bad && wr)
         for (int k = 0; k < n; k++) m[(b + k) % DP] = 8'(d >> (8 * (n - 1 - k)));
      if (!bad && !wr) begin
         v = 0;
         for (int k = 0; k < n; k++) v = (v << 8) | 32'(m[(b + k) % DP]);
         if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
         dout_m = v;
      end
      @(negedge Clk);
      RAM_enable = 1'b1;
      RAM_OpCode = {2'($urandom), wr, sx, sz};
      Address = a;
      DataIn = d;
      @(posedge Clk);
      lat = 0;
      while (lat < 40) begin
         @(negedge Clk);
         RAM_OpCode = 6'($urandom);
         Address = 9'($urandom);
         DataIn = $urandom;
         RAM_enable = (lat + 1 < hold);
         @(posedge Clk);
         lat++;
         #1;
         if (MFC) break;
      end
      chk("latency", lat, WS + 2);
      chk("dataout", DataOut, dout_m);
      chk("mset", {31'b0, MSET}, {31'b0, bad});
      do begin
         @(negedge Clk);
         RAM_enable = (lat + 1 < hold);
         lat++;
         @(posedge Clk);
         #1;
         chk("mfc_once", {31'b0, MFC}, 0);
         chk("mset_idle", {31'b0, MSET}, 0);
      end while (RAM_enable);
   endtask

   // word write interrupted by reset 'at' edges after acceptance
   task automatic abort_xact(input logic [8:0] a, input logic [31:0] d, input int at);
      @(negedge Clk);
      RAM_enable = 1'b1;
      RAM_OpCode = 6'b001010;
      Address = a;
      DataIn = d;
      @(posedge Clk);
      repeat (at - 1) @(posedge Clk);
      @(negedge Clk);
      RESET = 1'b1;
      RAM_enable = 1'b0;
      @(posedge Clk);
      #1;
      dout_m = 0;
      chk("abort_mfc", {31'b0, MFC}, 0);
      chk("abort_dout", DataOut, 0);
      @(negedge Clk);
      RESET = 1'b0;
      repeat (WS + 3) begin
         @(posedge Clk);
         #1;
         chk("abort_quiet", {31'b0, MFC}, 0);
      end
   endtask

   initial begin
      RESET = 1'b1;
      RAM_enable = 1'b0;
      RAM_OpCode = '0;
      Address = '0;
      DataIn = '0;
      dout_m = 0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_dout", DataOut, 0);
      chk("rst_mfc", {31'b0, MFC}, 0);
      chk("rst_mset", {31'b0, MSET}, 0);
      @(negedge Clk);
      RESET = 1'b0;
      for (int i = 0; i < DP; i += 4) xact(1'b1, 2'b10, 1'b0, 9'(i), $urandom, 1);
      xact(1'b1, 2'b10, 1'b0, 9'd0, 32'h8200_2001, 1);
      xact(1'b0, 2'b10, 1'b0, 9'd0, 0, 1);
      chk("word0", DataOut, 32'h8200_2001);
      xact(1'b0, 2'b00, 1'b1, 9'd0, 0, 1);
      chk("byte_sx", DataOut, 32'hFFFF_FF82);
      xact(1'b0, 2'b00, 1'b0, 9'd0, 0, 1);
      chk("byte_zx", DataOut, 32'h0000_0082);
      xact(1'b1, 2'b10, 1'b0, 9'd4, 32'hDEAD_BEEF, 10);
      xact(1'b0, 2'b10, 1'b0, 9'd4, 0, 10);
      chk("word4", DataOut, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) xact(1'b0, 2'b00, 1'b0, 9'(4 + i), 0, 1);
      chk("byte7", DataOut, 32'h0000_00EF);
      xact(1'b0, 2'b10, 1'b0, 9'd6, 0, 1);
      xact(1'b0, 2'b01, 1'b1, 9'd5, 0, 2);
      abort_xact(9'd8, 32'h1234_5678, 1);
      xact(1'b0, 2'b10, 1'b0, 9'd8, 0, 1);
      abort_xact(9'd12, 32'hCAFE_F00D, WS + 2);
      xact(1'b0, 2'b10, 1'b0, 9'd12, 0, 1);
      for (int i = 0; i < 150; i++)
         xact(1'($urandom), 2'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 9'($urandom_range(500, 511)) : 9'($urandom),
              $urandom, $urandom_range(1, 6));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
